lbp_stream_engine: RTL

- Parametrised streaming LBP engine for IMG_W x IMG_H grayscale images.
- Reads each gray pixel exactly once, in raster order. Two on-chip line buffers plus a 3x3 window register replace the 9-reads-per-pixel scheme.
- Sustains one LBP result per cycle once the pipeline is full.
- Sits between the gray-image ROM port and the LBP result RAM port.

---
 rtl/lbp_stream_engine.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/lbp_stream_engine.sv
`default_nettype none
// ============================================================================
// Module   : lbp_stream_engine
// Purpose  : Streaming 3x3 Local Binary Pattern engine. Reads each gray
//            pixel once in raster order and uses two line buffers plus a
//            sliding window to produce one LBP code per interior pixel.
// Options  : LBP_BORDER_EN - when defined, writes code 0 to every border
//            pixel after the interior results.
// Revision : 1.0 - initial release
// ============================================================================
module lbp_stream_engine #(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int DATA_W = 8,
  parameter int ADDR_W = $clog2(IMG_W*IMG_H)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gray_ready,
  output logic              gray_req,
  output logic [ADDR_W-1:0] gray_addr,
  input  logic [DATA_W-1:0] gray_data,
  output logic              lbp_valid,
  output logic [ADDR_W-1:0] lbp_addr,
  output logic [7:0]        lbp_data,
  output logic              finish
);

  localparam int c_col_w = $clog2(IMG_W);
  localparam int c_row_w = $clog2(IMG_H);
  localparam logic [c_col_w-1:0] c_last_col = c_col_w'(IMG_W-1);
  localparam logic [c_row_w-1:0] c_last_row = c_row_w'(IMG_H-1);
  // Distance from the newest pixel back to the window centre (one row, one column).
  localparam logic [ADDR_W-1:0]  c_ctr_ofs  = ADDR_W'(IMG_W+1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_FLUSH  = 3'd2,
`ifdef LBP_BORDER_EN
    S_BORDER = 3'd3,
`endif
    S_DONE   = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  logic [c_row_w-1:0]  r_rd_r;
  logic [c_col_w-1:0]  r_rd_c;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic                w_last_read;
  logic                w_win_valid;

  logic [DATA_W-1:0]   r_lb1 [IMG_W];   // row r-1
  logic [DATA_W-1:0]   r_lb2 [IMG_W];   // row r-2
  // The two older window columns; the newest column is taken live from the
  // line buffers and the ROM so the code is ready in the read cycle.
  logic [DATA_W-1:0]   r_win [3][2];
  logic [DATA_W-1:0]   w_win [3][3];
  logic [DATA_W-1:0]   w_ctr;
  logic [7:0]          w_code;

  logic                r_lbp_valid;
  logic [ADDR_W-1:0]   r_lbp_addr;
  logic [7:0]          r_lbp_data;

`ifdef LBP_BORDER_EN
  localparam int c_border_n = 2*IMG_W + 2*IMG_H - 4;
  localparam int c_bidx_w   = $clog2(c_border_n);
  localparam logic [c_bidx_w-1:0] c_bidx_last = c_bidx_w'(c_border_n-1);
  // First walk index of the right column, bottom row and left column.
  localparam logic [c_bidx_w-1:0] c_seg_right  = c_bidx_w'(IMG_W);
  localparam logic [c_bidx_w-1:0] c_seg_bottom = c_bidx_w'(IMG_W+IMG_H-1);
  localparam logic [c_bidx_w-1:0] c_seg_left   = c_bidx_w'(2*IMG_W+IMG_H-2);

  logic [c_bidx_w-1:0] r_bidx;
  logic [c_bidx_w-1:0] w_bidx_next;
  logic [ADDR_W-1:0]   w_baddr_next;

  // Next border address: step direction depends on which edge the next index lies on.
  always_comb begin
    w_bidx_next  = r_bidx + c_bidx_w'(1);
    w_baddr_next = r_lbp_addr;
    if (w_bidx_next < c_seg_right)
      w_baddr_next = r_lbp_addr + ADDR_W'(1);
    else if (w_bidx_next < c_seg_bottom)
      w_baddr_next = r_lbp_addr + ADDR_W'(IMG_W);
    else if (w_bidx_next < c_seg_left)
      w_baddr_next = r_lbp_addr - ADDR_W'(1);
    else
      w_baddr_next = r_lbp_addr - ADDR_W'(IMG_W);
  end
`endif

  assign w_last_read = (r_rd_r == c_last_row) && (r_rd_c == c_last_col);
  // Columns 0 and 1 of a row still hold the previous row's tail in the window.
  assign w_win_valid = (r_rd_r >= c_row_w'(2)) && (r_rd_c >= c_col_w'(2));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state decode and the combinational strobes.
  always_comb begin
    w_state_next = r_state;
    gray_req     = 1'b0;
    finish       = 1'b0;
    case (r_state)
      S_IDLE:  if (gray_ready) w_state_next = S_RUN;
      S_RUN: begin
        gray_req = 1'b1;
        if (w_last_read) w_state_next = S_FLUSH;
      end
`ifdef LBP_BORDER_EN
      S_FLUSH:  w_state_next = S_BORDER;
      S_BORDER: if (r_bidx == c_bidx_last) w_state_next = S_DONE;
`else
      S_FLUSH:  w_state_next = S_DONE;
`endif
      S_DONE: begin
        finish       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign gray_addr = gray_req ? r_rd_addr : '0;

  // Raster read counters; held at zero outside RUN so every image restarts at pixel 0.
  always_ff @(posedge clk) begin
    if (reset || (r_state != S_RUN)) begin
      r_rd_r    <= '0;
      r_rd_c    <= '0;
      r_rd_addr <= '0;
    end else begin
      r_rd_addr <= r_rd_addr + ADDR_W'(1);
      if (r_rd_c == c_last_col) begin
        r_rd_c <= '0;
        r_rd_r <= r_rd_r + c_row_w'(1);
      end else begin
        r_rd_c <= r_rd_c + c_col_w'(1);
      end
    end
  end

  // Assemble the current 3x3 window: two stored columns plus the incoming column.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_win[i][0] = r_win[i][0];
      w_win[i][1] = r_win[i][1];
    end
    w_win[0][2] = r_lb2[r_rd_c];
    w_win[1][2] = r_lb1[r_rd_c];
    w_win[2][2] = gray_data;
  end

  assign w_ctr  = w_win[1][1];
  assign w_code = {w_win[2][2] >= w_ctr, w_win[2][1] >= w_ctr, w_win[2][0] >= w_ctr,
                   w_win[1][2] >= w_ctr, w_win[1][0] >= w_ctr,
                   w_win[0][2] >= w_ctr, w_win[0][1] >= w_ctr, w_win[0][0] >= w_ctr};

  // Line buffers (read-before-write per column) and window shift; no reset needed.
  always_ff @(posedge clk) begin
    if (r_state == S_RUN) begin
      r_lb2[r_rd_c] <= r_lb1[r_rd_c];
      r_lb1[r_rd_c] <= gray_data;
      for (int i = 0; i < 3; i++) begin
        r_win[i][0] <= w_win[i][1];
        r_win[i][1] <= w_win[i][2];
      end
    end
  end

  // Registered result port: interior codes during RUN, zero codes along the border.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lbp_valid <= 1'b0;
      r_lbp_addr  <= '0;
      r_lbp_data  <= '0;
`ifdef LBP_BORDER_EN
      r_bidx      <= '0;
`endif
    end else begin
      r_lbp_valid <= 1'b0;
      if ((r_state == S_RUN) && w_win_valid) begin
        r_lbp_valid <= 1'b1;
        r_lbp_addr  <= r_rd_addr - c_ctr_ofs;
        r_lbp_data  <= w_code;
      end
`ifdef LBP_BORDER_EN
      else if (r_state == S_FLUSH) begin
        r_lbp_valid <= 1'b1;
        r_lbp_addr  <= '0;
        r_lbp_data  <= '0;
        r_bidx      <= '0;
      end else if ((r_state == S_BORDER) && (r_bidx != c_bidx_last)) begin
        r_lbp_valid <= 1'b1;
        r_lbp_addr  <= w_baddr_next;
        r_lbp_data  <= '0;
        r_bidx      <= w_bidx_next;
      end
`endif
    end
  end

  assign lbp_valid = r_lbp_valid;
  assign lbp_addr  = r_lbp_addr;
  assign lbp_data  = r_lbp_data;

endmodule
`default_nettype wire
